view_transform: RTL and testbench

//  Consumer of the virtual camera state: maps scanned 3D points to 2D screen pixels.

---
 rtl/view_transform.sv | 313 +++++++++++++++++++++++++++++++
 tb/tb_view_transform.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/view_transform.sv
// Three-stage camera view transform: Y-axis rotation from a 72-entry trig ROM, then translation and screen clip.
// Define CLIP_EN to drop offscreen points; by default they are clamped to the screen edge and flagged.
module view_transform #(
    parameter int unsigned SCREEN_W = 1024,
    parameter int unsigned SCREEN_H = 768,
    parameter int unsigned INIT_X   = 300,
    parameter int unsigned INIT_Y   = 300
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [10:0]       x_offset,
    input  logic [10:0]       y_offset,
    input  logic [8:0]        angle,
    input  logic              frame_start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic signed [9:0] px,
    input  logic signed [9:0] py,
    input  logic signed [9:0] pz,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [10:0]       pix_x,
    output logic [10:0]       pix_y,
    output logic              offscreen
);

    localparam logic [13:0] W_LIM = 14'(SCREEN_W);
    localparam logic [13:0] H_LIM = 14'(SCREEN_H);
`ifndef CLIP_EN
    localparam logic [10:0] X_MAX = 11'(SCREEN_W - 1);
    localparam logic [10:0] Y_MAX = 11'(SCREEN_H - 1);
`endif

    logic [10:0] snap_x_q, snap_x_d;
    logic [10:0] snap_y_q, snap_y_d;
    logic [8:0]  snap_a_q, snap_a_d;

    logic [6:0]        ang_idx;
    logic signed [9:0] rom_cos, rom_sin;

    logic              s1_valid_q, s1_valid_d;
    logic signed [9:0] s1_px_q, s1_px_d, s1_py_q, s1_py_d, s1_pz_q, s1_pz_d;
    logic [10:0]       s1_x_q, s1_x_d, s1_y_q, s1_y_d;
    logic signed [9:0] s1_cos_q, s1_cos_d, s1_sin_q, s1_sin_d;

    logic               s2_valid_q, s2_valid_d;
    logic signed [9:0]  s2_py_q, s2_py_d;
    logic [10:0]        s2_x_q, s2_x_d, s2_y_q, s2_y_d;
    logic signed [19:0] s2_pc_q, s2_pc_d, s2_ps_q, s2_ps_d;

    logic               out_valid_q, out_valid_d;
    logic [10:0]        pix_x_q, pix_x_d, pix_y_q, pix_y_d;
`ifndef CLIP_EN
    logic               offscreen_q, offscreen_d;
`endif

    logic signed [20:0] diff;
    logic signed [12:0] rx;
    logic signed [13:0] sx, sy;
    logic               off_x, off_y, off;
    logic               advance;

    assign advance   = !(out_valid_q && !out_ready);
    assign in_ready  = advance;
    assign out_valid = out_valid_q;
    assign pix_x     = pix_x_q;
    assign pix_y     = pix_y_q;
`ifdef CLIP_EN
    assign offscreen = 1'b0;
`else
    assign offscreen = offscreen_q;
`endif

    // The _d values double as the bypass: a point accepted with frame_start sees the new camera.
    always_comb begin
        snap_x_d = snap_x_q;
        snap_y_d = snap_y_q;
        snap_a_d = snap_a_q;
        if (frame_start) begin
            snap_x_d = x_offset;
            snap_y_d = y_offset;
            snap_a_d = angle;
        end
    end

    always_comb begin
        ang_idx = '0;
        if (snap_a_d < 9'd360) begin
            ang_idx = 7'(snap_a_d / 9'd5);
        end
    end

    always_comb begin
        rom_cos = '0;
        rom_sin = '0;
        case (ang_idx)
            7'd0:  begin rom_cos =  10'sd256; rom_sin =  10'sd0;   end
            7'd1:  begin rom_cos =  10'sd255; rom_sin =  10'sd22;  end
            7'd2:  begin rom_cos =  10'sd252; rom_sin =  10'sd44;  end
            7'd3:  begin rom_cos =  10'sd247; rom_sin =  10'sd66;  end
            7'd4:  begin rom_cos =  10'sd241; rom_sin =  10'sd88;  end
            7'd5:  begin rom_cos =  10'sd232; rom_sin =  10'sd108; end
            7'd6:  begin rom_cos =  10'sd222; rom_sin =  10'sd128; end
            7'd7:  begin rom_cos =  10'sd210; rom_sin =  10'sd147; end
            7'd8:  begin rom_cos =  10'sd196; rom_sin =  10'sd165; end
            7'd9:  begin rom_cos =  10'sd181; rom_sin =  10'sd181; end
            7'd10: begin rom_cos =  10'sd165; rom_sin =  10'sd196; end
            7'd11: begin rom_cos =  10'sd147; rom_sin =  10'sd210; end
            7'd12: begin rom_cos =  10'sd128; rom_sin =  10'sd222; end
            7'd13: begin rom_cos =  10'sd108; rom_sin =  10'sd232; end
            7'd14: begin rom_cos =  10'sd88;  rom_sin =  10'sd241; end
            7'd15: begin rom_cos =  10'sd66;  rom_sin =  10'sd247; end
            7'd16: begin rom_cos =  10'sd44;  rom_sin =  10'sd252; end
            7'd17: begin rom_cos =  10'sd22;  rom_sin =  10'sd255; end
            7'd18: begin rom_cos =  10'sd0;   rom_sin =  10'sd256; end
            7'd19: begin rom_cos = -10'sd22;  rom_sin =  10'sd255; end
            7'd20: begin rom_cos = -10'sd44;  rom_sin =  10'sd252; end
            7'd21: begin rom_cos = -10'sd66;  rom_sin =  10'sd247; end
            7'd22: begin rom_cos = -10'sd88;  rom_sin =  10'sd241; end
            7'd23: begin rom_cos = -10'sd108; rom_sin =  10'sd232; end
            7'd24: begin rom_cos = -10'sd128; rom_sin =  10'sd222; end
            7'd25: begin rom_cos = -10'sd147; rom_sin =  10'sd210; end
            7'd26: begin rom_cos = -10'sd165; rom_sin =  10'sd196; end
            7'd27: begin rom_cos = -10'sd181; rom_sin =  10'sd181; end
            7'd28: begin rom_cos = -10'sd196; rom_sin =  10'sd165; end
            7'd29: begin rom_cos = -10'sd210; rom_sin =  10'sd147; end
            7'd30: begin rom_cos = -10'sd222; rom_sin =  10'sd128; end
            7'd31: begin rom_cos = -10'sd232; rom_sin =  10'sd108; end
            7'd32: begin rom_cos = -10'sd241; rom_sin =  10'sd88;  end
            7'd33: begin rom_cos = -10'sd247; rom_sin =  10'sd66;  end
            7'd34: begin rom_cos = -10'sd252; rom_sin =  10'sd44;  end
            7'd35: begin rom_cos = -10'sd255; rom_sin =  10'sd22;  end
            7'd36: begin rom_cos = -10'sd256; rom_sin =  10'sd0;   end
            7'd37: begin rom_cos = -10'sd255; rom_sin = -10'sd22;  end
            7'd38: begin rom_cos = -10'sd252; rom_sin = -10'sd44;  end
            7'd39: begin rom_cos = -10'sd247; rom_sin = -10'sd66;  end
            7'd40: begin rom_cos = -10'sd241; rom_sin = -10'sd88;  end
            7'd41: begin rom_cos = -10'sd232; rom_sin = -10'sd108; end
            7'd42: begin rom_cos = -10'sd222; rom_sin = -10'sd128; end
            7'd43: begin rom_cos = -10'sd210; rom_sin = -10'sd147; end
            7'd44: begin rom_cos = -10'sd196; rom_sin = -10'sd165; end
            7'd45: begin rom_cos = -10'sd181; rom_sin = -10'sd181; end
            7'd46: begin rom_cos = -10'sd165; rom_sin = -10'sd196; end
            7'd47: begin rom_cos = -10'sd147; rom_sin = -10'sd210; end
            7'd48: begin rom_cos = -10'sd128; rom_sin = -10'sd222; end
            7'd49: begin rom_cos = -10'sd108; rom_sin = -10'sd232; end
            7'd50: begin rom_cos = -10'sd88;  rom_sin = -10'sd241; end
            7'd51: begin rom_cos = -10'sd66;  rom_sin = -10'sd247; end
            7'd52: begin rom_cos = -10'sd44;  rom_sin = -10'sd252; end
            7'd53: begin rom_cos = -10'sd22;  rom_sin = -10'sd255; end
            7'd54: begin rom_cos =  10'sd0;   rom_sin = -10'sd256; end
            7'd55: begin rom_cos =  10'sd22;  rom_sin = -10'sd255; end
            7'd56: begin rom_cos =  10'sd44;  rom_sin = -10'sd252; end
            7'd57: begin rom_cos =  10'sd66;  rom_sin = -10'sd247; end
            7'd58: begin rom_cos =  10'sd88;  rom_sin = -10'sd241; end
            7'd59: begin rom_cos =  10'sd108; rom_sin = -10'sd232; end
            7'd60: begin rom_cos =  10'sd128; rom_sin = -10'sd222; end
            7'd61: begin rom_cos =  10'sd147; rom_sin = -10'sd210; end
            7'd62: begin rom_cos =  10'sd165; rom_sin = -10'sd196; end
            7'd63: begin rom_cos =  10'sd181; rom_sin = -10'sd181; end
            7'd64: begin rom_cos =  10'sd196; rom_sin = -10'sd165; end
            7'd65: begin rom_cos =  10'sd210; rom_sin = -10'sd147; end
            7'd66: begin rom_cos =  10'sd222; rom_sin = -10'sd128; end
            7'd67: begin rom_cos =  10'sd232; rom_sin = -10'sd108; end
            7'd68: begin rom_cos =  10'sd241; rom_sin = -10'sd88;  end
            7'd69: begin rom_cos =  10'sd247; rom_sin = -10'sd66;  end
            7'd70: begin rom_cos =  10'sd252; rom_sin = -10'sd44;  end
            7'd71: begin rom_cos =  10'sd255; rom_sin = -10'sd22;  end
            default: begin rom_cos = '0; rom_sin = '0; end
        endcase
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_px_d    = s1_px_q;
        s1_py_d    = s1_py_q;
        s1_pz_d    = s1_pz_q;
        s1_x_d     = s1_x_q;
        s1_y_d     = s1_y_q;
        s1_cos_d   = s1_cos_q;
        s1_sin_d   = s1_sin_q;
        if (advance) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_px_d  = px;
                s1_py_d  = py;
                s1_pz_d  = pz;
                s1_x_d   = snap_x_d;
                s1_y_d   = snap_y_d;
                s1_cos_d = rom_cos;
                s1_sin_d = rom_sin;
            end
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_py_d    = s2_py_q;
        s2_x_d     = s2_x_q;
        s2_y_d     = s2_y_q;
        s2_pc_d    = s2_pc_q;
        s2_ps_d    = s2_ps_q;
        if (advance) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_py_d = s1_py_q;
                s2_x_d  = s1_x_q;
                s2_y_d  = s1_y_q;
                s2_pc_d = 20'(s1_px_q) * 20'(s1_cos_q);
                s2_ps_d = 20'(s1_pz_q) * 20'(s1_sin_q);
            end
        end
    end

    // Taking bits above the arithmetic shift gives floor division of the rotated X by 256.
    always_comb begin
        diff  = 21'(s2_pc_q) - 21'(s2_ps_q);
        rx    = 13'(diff >>> 8);
        sx    = $signed({3'b000, s2_x_q}) + 14'(rx);
        sy    = $signed({3'b000, s2_y_q}) - 14'(s2_py_q);
        off_x = sx[13] || ($unsigned(sx) >= W_LIM);
        off_y = sy[13] || ($unsigned(sy) >= H_LIM);
        off   = off_x || off_y;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        pix_x_d     = pix_x_q;
        pix_y_d     = pix_y_q;
`ifdef CLIP_EN
        if (advance) begin
            out_valid_d = s2_valid_q && !off;
            if (s2_valid_q && !off) begin
                pix_x_d = sx[10:0];
                pix_y_d = sy[10:0];
            end
        end
`else
        offscreen_d = offscreen_q;
        if (advance) begin
            out_valid_d = s2_valid_q;
            if (s2_valid_q) begin
                offscreen_d = off;
                if (sx[13])
                    pix_x_d = '0;
                else if ($unsigned(sx) >= W_LIM)
                    pix_x_d = X_MAX;
                else
                    pix_x_d = sx[10:0];
                if (sy[13])
                    pix_y_d = '0;
                else if ($unsigned(sy) >= H_LIM)
                    pix_y_d = Y_MAX;
                else
                    pix_y_d = sy[10:0];
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap_x_q    <= 11'(INIT_X);
            snap_y_q    <= 11'(INIT_Y);
            snap_a_q    <= '0;
            s1_valid_q  <= 1'b0;
            s1_px_q     <= '0;
            s1_py_q     <= '0;
            s1_pz_q     <= '0;
            s1_x_q      <= '0;
            s1_y_q      <= '0;
            s1_cos_q    <= '0;
            s1_sin_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_py_q     <= '0;
            s2_x_q      <= '0;
            s2_y_q      <= '0;
            s2_pc_q     <= '0;
            s2_ps_q     <= '0;
            out_valid_q <= 1'b0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
`ifndef CLIP_EN
            offscreen_q <= 1'b0;
`endif
        end else begin
            snap_x_q    <= snap_x_d;
            snap_y_q    <= snap_y_d;
            snap_a_q    <= snap_a_d;
            s1_valid_q  <= s1_valid_d;
            s1_px_q     <= s1_px_d;
            s1_py_q     <= s1_py_d;
            s1_pz_q     <= s1_pz_d;
            s1_x_q      <= s1_x_d;
            s1_y_q      <= s1_y_d;
            s1_cos_q    <= s1_cos_d;
            s1_sin_q    <= s1_sin_d;
            s2_valid_q  <= s2_valid_d;
            s2_py_q     <= s2_py_d;
            s2_x_q      <= s2_x_d;
            s2_y_q      <= s2_y_d;
            s2_pc_q     <= s2_pc_d;
            s2_ps_q     <= s2_ps_d;
            out_valid_q <= out_valid_d;
            pix_x_q     <= pix_x_d;
            pix_y_q     <= pix_y_d;
`ifndef CLIP_EN
            offscreen_q <= offscreen_d;
`endif
        end
    end

endmodule

// File: tb/tb_view_transform.sv
// Bench for view_transform: directed camera scenarios plus randomized streaming against a trig reference model.
module tb_view_transform;

    localparam int SCR_W = 1024;
    localparam int SCR_H = 768;

    logic              clk = 1'b0;
    logic              reset;
    logic [10:0]       x_offset, y_offset;
    logic [8:0]        angle;
    logic              frame_start, in_valid, in_ready;
    logic signed [9:0] px, py, pz;
    logic              out_valid, out_ready;
    logic [10:0]       pix_x, pix_y;
    logic              offscreen;

    view_transform #(
        .SCREEN_W(1024), .SCREEN_H(768), .INIT_X(300), .INIT_Y(300)
    ) dut (
        .clk(clk), .reset(reset), .x_offset(x_offset), .y_offset(y_offset),
        .angle(angle), .frame_start(frame_start), .in_valid(in_valid),
        .in_ready(in_ready), .px(px), .py(py), .pz(pz), .out_valid(out_valid),
        .out_ready(out_ready), .pix_x(pix_x), .pix_y(pix_y), .offscreen(offscreen)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    typedef struct { int x; int y; int off; } pix_t;
    pix_t exp_q[$];
    int   log_x[$], log_y[$], log_off[$];
    int   n_out = 0;
    int   m_x = 300, m_y = 300, m_a = 0;
    bit   hold_prev = 0, saw_stall = 0;
    int   held_x, held_y, held_off;

    function automatic int trig256(input int deg, input bit want_sin);
        real r, v;
        r = real'(deg) * 3.14159265358979 / 180.0;
        v = want_sin ? $sin(r) : $cos(r);
        return int'($floor(256.0 * v + 0.5));
    endfunction

    // Reference projection; returns 0 when the point produces no output.
    function automatic bit project(input int xo, input int yo, input int a,
                                   input int x, input int y, input int z, output pix_t p);
        int deg, c, s, sx, sy;
        bit off;
        deg = (a >= 360) ? 0 : (a / 5) * 5;
        c   = trig256(deg, 0);
        s   = trig256(deg, 1);
        sx  = xo + int'($floor(real'(x * c - z * s) / 256.0));
        sy  = yo - y;
        off = (sx < 0) || (sx >= SCR_W) || (sy < 0) || (sy >= SCR_H);
        p.off = off;
        p.x = (sx < 0) ? 0 : (sx >= SCR_W) ? SCR_W - 1 : sx;
        p.y = (sy < 0) ? 0 : (sy >= SCR_H) ? SCR_H - 1 : sy;
`ifdef CLIP_EN
        p.off = 0;
        return !off;
`else
        return 1'b1;
`endif
    endfunction

    always @(negedge clk) begin
        pix_t e;
        if (!reset) begin
            check("in_ready_rule", in_ready, !(out_valid && !out_ready));
            if (!in_ready) saw_stall = 1;
            if (hold_prev) begin
                check("hold_valid", out_valid, 1);
                check("hold_pix_x", pix_x, held_x);
                check("hold_pix_y", pix_y, held_y);
                check("hold_off", offscreen, held_off);
            end
            hold_prev = out_valid && !out_ready;
            held_x = pix_x; held_y = pix_y; held_off = offscreen;
            if (out_valid && out_ready) begin
                n_out++;
                log_x.push_back(pix_x); log_y.push_back(pix_y); log_off.push_back(offscreen);
                if (exp_q.size() == 0) begin
                    check("spurious_out", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("pix_x", pix_x, e.x);
                    check("pix_y", pix_y, e.y);
                    check("offscreen", offscreen, e.off);
                end
            end
            if (frame_start) begin
                m_x = x_offset; m_y = y_offset; m_a = angle;
            end
            if (in_valid && in_ready) begin
                if (project(m_x, m_y, m_a, px, py, pz, e)) exp_q.push_back(e);
            end
        end
    end

    task automatic send(input int x, input int y, input int z, input bit fs,
                        input int xo, input int yo, input int a);
        bit acc = 0;
        x_offset = 11'(xo); y_offset = 11'(yo); angle = 9'(a);
        frame_start = fs;
        px = 10'(x); py = 10'(y); pz = 10'(z);
        in_valid = 1;
        for (int k = 0; k < 60 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            frame_start = 0;
        end
        in_valid = 0;
        if (!acc) check("send_timeout", 0, 1);
    endtask

    task automatic wait_outs(input int target, input string tag);
        int k = 0;
        while (n_out < target && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        check(tag, n_out >= target, 1);
    endtask

    task automatic do_reset();
        reset = 1; in_valid = 0; frame_start = 0;
        #1;
        check("reset_out_valid", out_valid, 0);
        exp_q.delete();
        m_x = 300; m_y = 300; m_a = 0;
        hold_prev = 0;
        repeat (2) @(posedge clk);
        #1 reset = 0;
    endtask

    initial begin
        int n0, lat;
        bit acc_last;
        reset = 1; in_valid = 0; frame_start = 0; out_ready = 1;
        x_offset = 0; y_offset = 0; angle = 0; px = 0; py = 0; pz = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_pix_x", pix_x, 0);
        check("rst_pix_y", pix_y, 0);
        check("rst_offscreen", offscreen, 0);
        reset = 0;
        @(posedge clk); #1;

        // T1: latency and basic translation
        n0 = n_out; lat = 0;
        x_offset = 300; y_offset = 300; angle = 0; frame_start = 1;
        px = 10; py = 20; pz = 30; in_valid = 1;
        for (int k = 1; k <= 10 && lat == 0; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin in_valid = 0; frame_start = 0; end
            if (out_valid) lat = k;
        end
        check("t1_latency", lat, 3);
        wait_outs(n0 + 1, "t1_out");
        check("t1_pix_x", log_x[n0], 310);
        check("t1_pix_y", log_y[n0], 280);
        check("t1_off", log_off[n0], 0);

        // T2: rotation and out-of-range angle
        n0 = n_out;
        send(10, 20, 30, 1, 300, 300, 90);
        send(10, 20, 30, 1, 300, 300, 180);
        send(10, 20, 30, 1, 300, 300, 361);
        wait_outs(n0 + 3, "t2_out");
        check("t2_a90_x", log_x[n0], 270);
        check("t2_a90_y", log_y[n0], 280);
        check("t2_a180_x", log_x[n0 + 1], 290);
        check("t2_a361_x", log_x[n0 + 2], 310);

        // T4: right-edge overflow
        n0 = n_out;
        send(100, 0, 0, 1, 1000, 300, 0);
`ifdef CLIP_EN
        repeat (8) @(posedge clk);
        #1;
        check("t4_dropped", n_out, n0);
`else
        wait_outs(n0 + 1, "t4_out");
        check("t4_pix_x", log_x[n0], 1023);
        check("t4_off", log_off[n0], 1);
`endif

        // T5: frame_start while earlier points are in flight
        n0 = n_out;
        send(10, 20, 30, 1, 300, 300, 0);
        send(10, 20, 30, 0, 300, 300, 0);
        send(10, 20, 30, 1, 300, 300, 90);
        wait_outs(n0 + 3, "t5_out");
        check("t5_p0_x", log_x[n0], 310);
        check("t5_p1_x", log_x[n0 + 1], 310);
        check("t5_p2_x", log_x[n0 + 2], 270);

        // T3: downstream stall while streaming six points
        n0 = n_out; saw_stall = 0;
        send(0, 0, 0, 1, 500, 400, 45);
        fork
            for (int i = 0; i < 6; i++)
                send($urandom_range(0, 400) - 200, $urandom_range(0, 400) - 200,
                     $urandom_range(0, 400) - 200, 0, 500, 400, 45);
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 0;
                repeat (5) @(posedge clk);
                #1 out_ready = 1;
            end
        join
        wait_outs(n0 + 7, "t3_out");
        check("t3_stall_seen", saw_stall, 1);
        check("t3_count", n_out, n0 + 7);

        // T6: reset with points in flight
        send(5, 5, 5, 1, 500, 100, 90);
        send(6, 6, 6, 0, 500, 100, 90);
        send(7, 7, 7, 0, 500, 100, 90);
        n0 = n_out;
        do_reset();
        repeat (8) @(posedge clk);
        #1;
        check("t6_no_output", n_out, n0);
        send(10, 20, 30, 0, 0, 0, 0);
        wait_outs(n0 + 1, "t6_out");
        check("t6_snap_x", log_x[n0], 310);
        check("t6_snap_y", log_y[n0], 280);

        // Randomized streaming with bubbles, backpressure and camera changes
        acc_last = 0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            frame_start = 0;
            if (!in_valid || acc_last) begin
                in_valid = ($urandom_range(0, 3) != 0);
                px = 10'($urandom); py = 10'($urandom); pz = 10'($urandom);
                if ($urandom_range(0, 7) == 0) begin
                    frame_start = 1;
                    x_offset = ($urandom_range(0, 3) == 0) ? 11'($urandom) : 11'($urandom_range(150, 850));
                    y_offset = ($urandom_range(0, 3) == 0) ? 11'($urandom) : 11'($urandom_range(150, 650));
                    angle = ($urandom_range(0, 9) == 0) ? 9'($urandom_range(356, 511))
                                                         : 9'($urandom_range(0, 71) * 5 + $urandom_range(0, 4));
                end
            end
            @(negedge clk);
            acc_last = in_valid && in_ready;
            @(posedge clk); #1;
        end
        in_valid = 0; frame_start = 0; out_ready = 1;
        repeat (10) @(posedge clk);
        #1;
        check("drain_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
